divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have parameter N, default 5, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a division; sampled on the clk edge.
REQ-005 The block SHALL have port x, input, N bits, unsigned dividend; sampled on the edge that accepts start.
REQ-006 The block SHALL have port y, input, N bits, unsigned divisor; sampled on the edge that accepts start.
REQ-007 The block SHALL have port q, output, N bits, unsigned quotient.
REQ-008 The block SHALL have port r, output, N bits, unsigned remainder.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, one-cycle pulse marking valid q/r.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit, flags that the latest result came from y = 0.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at a clk edge SHALL be accepted: the block latches x and y, clears the partial remainder and iteration counter, and moves to RUN; if y = 0 it moves directly to DONE instead.
REQ-014 start SHALL be ignored in RUN and DONE; operands held internally SHALL NOT change while busy=1.
REQ-015 In RUN, each clk edge SHALL perform one restoring iteration, MSB first: shift the (N+1)-bit partial remainder left, inserting the next dividend bit; trial-subtract the zero-extended divisor; if the result is non-negative, keep it and set the quotient bit to 1, else restore and set it to 0.
REQ-016 RUN SHALL last exactly N iterations, counted by a counter of width ceil(log2(N+1)); the Nth iteration edge SHALL move to DONE.
REQ-017 done SHALL be high exactly for the single cycle spent in DONE: N cycles after the accepting edge for y != 0, and 1 cycle after it for y = 0.
REQ-018 DONE SHALL unconditionally return to IDLE on the next edge; a start present in that cycle SHALL be ignored.
REQ-019 For y != 0, the result SHALL satisfy x = q*y + r with r < y; div_by_zero SHALL be 0.
REQ-020 For y = 0, the result SHALL be q = all ones and r = x, with div_by_zero = 1.
REQ-021 q, r and div_by_zero SHALL update only on entry to DONE and SHALL hold their values through IDLE until the next result.
REQ-022 busy SHALL be 1 in RUN and DONE and 0 in IDLE; a new start SHALL be accepted no earlier than the first IDLE cycle after done.

Reset
REQ-023 When rst=1, the block SHALL immediately, regardless of clk, force state IDLE, q=0, r=0, busy=0, done=0, div_by_zero=0, and clear the counter and partial remainder.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first accepted start after rst deasserts SHALL begin a fresh division.

Verification
REQ-025 The bench SHALL cover, with N=5, x=23, y=4 and a start pulse: busy rises next cycle; done pulses exactly 5 cycles after the accepting edge with q=5, r=3, div_by_zero=0.
REQ-026 The bench SHALL cover x=31, y=1 -> q=31, r=0; and x=7, y=9 -> q=0, r=7; each with done pulsing after 5 cycles.
REQ-027 The bench SHALL cover x=13, y=0 -> done 1 cycle after the accepting edge with q=31, r=13, div_by_zero=1; busy high for that one cycle only.
REQ-028 The bench SHALL cover start held high with new x/y during RUN and DONE -> no effect on the current result; the next division begins only on the first IDLE edge; its result is correct for the operands present then.
REQ-029 The bench SHALL cover rst asserted on iteration 3 of 23/4 -> all outputs 0 immediately, no done pulse; then 10/3 -> q=3, r=1.
REQ-030 The bench SHALL cover an exhaustive check of all 32x32 operand pairs against a reference model, including q/r holding stable between done pulses.

Source files
------------

// File: rtl/divider_if.sv
// Handshake and result bundle for the restoring divider.
// master drives the request; slave (the divider) returns the result.
interface divider_if #(parameter int N = 5);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (output start, x, y, input q, r, busy, done, div_by_zero);
    modport slave  (input start, x, y, output q, r, busy, done, div_by_zero);
endinterface

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
// Results are published only on entry to DONE and held until the next result.
module divider #(parameter int N = 5) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nstate;

    logic [CW-1:0] cnt;
    logic [N-1:0]  xd, yd, pr, pr_nxt;
    logic [N-2:0]  qw;
    logic [N:0]    rsh, trial;
    logic [N-1:0]  q_r, r_r;
    logic          dbz_r, nbit, qbit, last;

    // Dividend bits are selected by the counter so the latched operand never moves.
    always_comb begin
        nbit = 1'b0;
        for (int i = 0; i < N; i++)
            if (cnt == CW'(N - 1 - i)) nbit = xd[i];
    end

    // Partial remainder stays below the divisor, so the sign of an (N+1)-bit
    // trial difference is exact even when the shifted value reaches 2^N.
    assign rsh    = {pr, nbit};
    assign trial  = rsh - {1'b0, yd};
    assign qbit   = ~trial[N];
    assign pr_nxt = qbit ? trial[N-1:0] : rsh[N-1:0];
    assign last   = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (bus.start) nstate = (bus.y == '0) ? DONE : RUN;
            RUN:     if (last) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xd    <= '0;
            yd    <= '0;
            pr    <= '0;
            qw    <= '0;
            cnt   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    xd  <= bus.x;
                    yd  <= bus.y;
                    pr  <= '0;
                    qw  <= '0;
                    cnt <= '0;
                    if (bus.y == '0) begin
                        q_r   <= '1;
                        r_r   <= bus.x;
                        dbz_r <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    pr  <= pr_nxt;
                    qw  <= (N-1)'({qw, qbit});
                    if (last) begin
                        q_r   <= {qw, qbit};
                        r_r   <= pr_nxt;
                        dbz_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.q           = q_r;
    assign bus.r           = r_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases, then every 5-bit
// operand pair in shuffled order against an arithmetic reference.
module tb_divider;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    divider_if #(.N(N)) bus ();
    divider #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] eq, output logic [N-1:0] er);
        if (b == 0) begin
            eq = {N{1'b1}};
            er = a;
        end else begin
            eq = N'(a / b);
            er = N'(a % b);
        end
    endtask

    // Waits (bounded) for done after an accepting edge; returns edges elapsed.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] eq, er;
        int lat;
        model(a, b, eq, er);
        @(negedge clk);
        bus.start = 1'b1; bus.x = a; bus.y = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.x = N'($urandom); bus.y = N'($urandom);
        chk("busy_rise", 32'(bus.busy), 1);
        wait_done(lat);
        chk("latency", lat, (b == 0) ? 0 : N);
        chk("q", 32'(bus.q), 32'(eq));
        chk("r", 32'(bus.r), 32'(er));
        chk("dbz", 32'(bus.div_by_zero), 32'(b == 0));
        @(posedge clk); #1;
        chk("done_pulse", 32'(bus.done), 0);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("q_hold", 32'(bus.q), 32'(eq));
        chk("r_hold", 32'(bus.r), 32'(er));
    endtask

    initial begin
        int lat;
        int order[1024];

        bus.start = 1'b0; bus.x = '0; bus.y = '0;
        rst = 1'b1;
        #2;
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_r", 32'(bus.r), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        do_div(5'd23, 5'd4);
        do_div(5'd31, 5'd1);
        do_div(5'd7,  5'd9);
        do_div(5'd13, 5'd0);

        // start held through RUN and DONE with different operands
        @(negedge clk);
        bus.start = 1'b1; bus.x = 5'd23; bus.y = 5'd4;
        @(posedge clk); #1;
        chk("held_busy", 32'(bus.busy), 1);
        bus.x = 5'd10; bus.y = 5'd3;
        wait_done(lat);
        chk("held_lat1", lat, N);
        chk("held_q1", 32'(bus.q), 5);
        chk("held_r1", 32'(bus.r), 3);
        @(posedge clk); #1;
        chk("held_idle", 32'(bus.busy), 0);
        chk("held_qhold", 32'(bus.q), 5);
        @(posedge clk); #1;
        chk("held_accept", 32'(bus.busy), 1);
        bus.start = 1'b0; bus.x = 5'd17; bus.y = 5'd2;
        wait_done(lat);
        chk("held_lat2", lat, N);
        chk("held_q2", 32'(bus.q), 3);
        chk("held_r2", 32'(bus.r), 1);
        @(posedge clk); #1;

        // reset during the third iteration of 23/4
        @(negedge clk);
        bus.start = 1'b1; bus.x = 5'd23; bus.y = 5'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_q", 32'(bus.q), 0);
        chk("mid_rst_r", 32'(bus.r), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        chk("mid_rst_dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", 32'(bus.done), 0);
        end
        do_div(5'd10, 5'd3);

        // every operand pair, shuffled, with random idle gaps
        for (int i = 0; i < 1024; i++) order[i] = i;
        for (int i = 1023; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 1024; i++) begin
            do_div(N'(order[i] >> N), N'(order[i]));
            repeat ($urandom_range(1, 0)) @(posedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
